// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Hazard and forwarding controller for the ID->EXE->MEM->WB pipeline.
// It tracks in-flight destinations in shadow pipeline registers and keeps a
// per-register load scoreboard. From these it produces the IF/ID freeze,
// the IF/ID flush, and the operand forwarding selects for EXE and MEM.

module pipe_hazard_ctrl #(
   parameter int NREG     = 4,
   parameter int RA_W     = 2,
   parameter int LD_LAT   = 1,
   parameter int ZERO_REG = 0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            id_valid,
   input  logic [RA_W-1:0] id_src1,
   input  logic            id_src1_en,
   input  logic [RA_W-1:0] id_src2,
   input  logic            id_src2_en,
   input  logic [RA_W-1:0] id_dest,
   input  logic            id_wb_en,
   input  logic            id_mem_rd,
   input  logic            id_mem_wr,
   input  logic            id_br_taken,
   output logic            stall,
   output logic            flush_if,
   output logic [1:0]      fwd_sel1,
   output logic [1:0]      fwd_sel2,
   output logic            fwd_st
);

   localparam logic [2:0] LD_CNT = 3'(LD_LAT);

   // Shadow copies of what sits in each downstream stage
   logic            ex_v, ex_wb, ex_en1, ex_en2, ex_st;
   logic [RA_W-1:0] ex_dest, ex_src1, ex_src2;
   logic            mem_v, mem_wb, mem_st;
   logic [RA_W-1:0] mem_dest, mem_stsrc;
   logic            wb_v, wb_wb;
   logic [RA_W-1:0] wb_dest;

   // Remaining load-use stall cycles per architectural register
   logic [2:0]      rdy_cnt [NREG];

   logic            busy1, busy2, issue;

   // Register 0 is exempt from all hazard logic when it is hardwired to zero
   function automatic logic is_zero(input logic [RA_W-1:0] r);
      return (ZERO_REG != 0) && (r == '0);
   endfunction

   // Freeze and flush decisions from the instruction currently in ID
   always_comb begin
      busy1    = id_src1_en && !is_zero(id_src1) && (rdy_cnt[id_src1] != 3'd0);
      busy2    = id_src2_en && !is_zero(id_src2) && (rdy_cnt[id_src2] != 3'd0);
      stall    = id_valid && (busy1 || busy2);
      issue    = id_valid && !stall;
      flush_if = id_valid && id_br_taken && !stall;
   end

   // Operand forwarding into EXE and store-data forwarding into MEM; the
   // younger MEM result takes priority over the older WB value
   always_comb begin
      fwd_sel1 = 2'b00;
      fwd_sel2 = 2'b00;
      if (ex_v && ex_en1 && !is_zero(ex_src1)) begin
         if (mem_v && mem_wb && (mem_dest == ex_src1))
            fwd_sel1 = 2'b01;
         else if (wb_v && wb_wb && (wb_dest == ex_src1))
            fwd_sel1 = 2'b10;
      end
      if (ex_v && ex_en2 && !is_zero(ex_src2)) begin
         if (mem_v && mem_wb && (mem_dest == ex_src2))
            fwd_sel2 = 2'b01;
         else if (wb_v && wb_wb && (wb_dest == ex_src2))
            fwd_sel2 = 2'b10;
      end
      fwd_st = mem_v && mem_st && wb_v && wb_wb &&
               (wb_dest == mem_stsrc) && !is_zero(mem_stsrc);
   end

   // Advance the shadow pipeline; a stalled ID injects a bubble into EXE
   always_ff @(posedge clk) begin
      if (!rst) begin
         ex_v      <= 1'b0;
         ex_wb     <= 1'b0;
         ex_en1    <= 1'b0;
         ex_en2    <= 1'b0;
         ex_st     <= 1'b0;
         ex_dest   <= '0;
         ex_src1   <= '0;
         ex_src2   <= '0;
         mem_v     <= 1'b0;
         mem_wb    <= 1'b0;
         mem_st    <= 1'b0;
         mem_dest  <= '0;
         mem_stsrc <= '0;
         wb_v      <= 1'b0;
         wb_wb     <= 1'b0;
         wb_dest   <= '0;
      end else begin
         wb_v      <= mem_v;
         wb_wb     <= mem_wb;
         wb_dest   <= mem_dest;
         mem_v     <= ex_v;
         mem_wb    <= ex_wb;
         mem_st    <= ex_st;
         mem_dest  <= ex_dest;
         mem_stsrc <= ex_src1;
         if (issue) begin
            ex_v    <= 1'b1;
            ex_wb   <= id_wb_en;
            ex_en1  <= id_src1_en;
            ex_en2  <= id_src2_en;
            ex_st   <= id_mem_wr;
            ex_dest <= id_dest;
            ex_src1 <= id_src1;
            ex_src2 <= id_src2;
         end else begin
            ex_v    <= 1'b0;
            ex_wb   <= 1'b0;
            ex_en1  <= 1'b0;
            ex_en2  <= 1'b0;
            ex_st   <= 1'b0;
         end
      end
   end

   // Load scoreboard: an issuing load arms its destination, an issuing
   // non-load writer to the same register cancels it (forwarding covers it),
   // and every other armed counter drains by one per cycle
   always_ff @(posedge clk) begin
      for (int r = 0; r < NREG; r++) begin
         if (!rst)
            rdy_cnt[r] <= 3'd0;
         else if (issue && id_wb_en && (id_dest == RA_W'(r)) && !is_zero(id_dest))
            rdy_cnt[r] <= id_mem_rd ? LD_CNT : 3'd0;
         else if (rdy_cnt[r] != 3'd0)
            rdy_cnt[r] <= rdy_cnt[r] - 3'd1;
      end
   end

   // A branch can only flush once it is free to issue
   assert property (@(posedge clk) disable iff (!rst) !(stall && flush_if));

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl
// Scripted instruction streams are fed to three configurations of the
// controller (LD_LAT=1, LD_LAT=3, LD_LAT=1 with hardwired r0). Expected
// outputs are queued as each instruction is presented and compared when
// the outputs settle.

module tb_pipe_hazard_ctrl;

   typedef struct packed {
      logic       v;
      logic [1:0] s1;
      logic       e1;
      logic [1:0] s2;
      logic       e2;
      logic [1:0] d;
      logic       wb;
      logic       rd;
      logic       wr;
      logic       br;
   } ins_t;

   // Observed vector layout: {stall, flush_if, fwd_sel1, fwd_sel2, fwd_st}
   localparam logic [6:0] E_IDLE  = 7'b0000000;
   localparam logic [6:0] E_STALL = 7'b1000000;
   localparam logic [6:0] E_FLUSH = 7'b0100000;
   localparam logic [6:0] E_S1M   = 7'b0001000;
   localparam logic [6:0] E_S1W   = 7'b0010000;
   localparam logic [6:0] E_S2M   = 7'b0000010;
   localparam logic [6:0] E_ST    = 7'b0000001;

   logic       clk = 1'b0;
   logic       rst;
   logic       id_valid, id_src1_en, id_src2_en, id_wb_en, id_mem_rd, id_mem_wr, id_br_taken;
   logic [1:0] id_src1, id_src2, id_dest;

   logic       stall_a, flush_a, st_a, stall_b, flush_b, st_b, stall_c, flush_c, st_c;
   logic [1:0] sel1_a, sel2_a, sel1_b, sel2_b, sel1_c, sel2_c;
   logic [6:0] obs_a, obs_b, obs_c;

   logic [6:0] sb [$];
   int         checks = 0;
   int         passes = 0;

   assign obs_a = {stall_a, flush_a, sel1_a, sel2_a, st_a};
   assign obs_b = {stall_b, flush_b, sel1_b, sel2_b, st_b};
   assign obs_c = {stall_c, flush_c, sel1_c, sel2_c, st_c};

   // Free-running clock, rising edges at 5, 15, 25, ...
   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.NREG(4), .RA_W(2), .LD_LAT(1), .ZERO_REG(0)) dut_a (
      .clk(clk), .rst(rst), .id_valid(id_valid),
      .id_src1(id_src1), .id_src1_en(id_src1_en), .id_src2(id_src2), .id_src2_en(id_src2_en),
      .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_rd(id_mem_rd), .id_mem_wr(id_mem_wr),
      .id_br_taken(id_br_taken), .stall(stall_a), .flush_if(flush_a),
      .fwd_sel1(sel1_a), .fwd_sel2(sel2_a), .fwd_st(st_a));

   pipe_hazard_ctrl #(.NREG(4), .RA_W(2), .LD_LAT(3), .ZERO_REG(0)) dut_b (
      .clk(clk), .rst(rst), .id_valid(id_valid),
      .id_src1(id_src1), .id_src1_en(id_src1_en), .id_src2(id_src2), .id_src2_en(id_src2_en),
      .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_rd(id_mem_rd), .id_mem_wr(id_mem_wr),
      .id_br_taken(id_br_taken), .stall(stall_b), .flush_if(flush_b),
      .fwd_sel1(sel1_b), .fwd_sel2(sel2_b), .fwd_st(st_b));

   pipe_hazard_ctrl #(.NREG(4), .RA_W(2), .LD_LAT(1), .ZERO_REG(1)) dut_c (
      .clk(clk), .rst(rst), .id_valid(id_valid),
      .id_src1(id_src1), .id_src1_en(id_src1_en), .id_src2(id_src2), .id_src2_en(id_src2_en),
      .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_rd(id_mem_rd), .id_mem_wr(id_mem_wr),
      .id_br_taken(id_br_taken), .stall(stall_c), .flush_if(flush_c),
      .fwd_sel1(sel1_c), .fwd_sel2(sel2_c), .fwd_st(st_c));

   // Instruction builders
   function automatic ins_t f_nop();
      return '0;
   endfunction

   function automatic ins_t f_alu(input logic [1:0] d, input logic [1:0] s1, input logic [1:0] s2);
      ins_t i = '0;
      i.v = 1'b1; i.d = d; i.wb = 1'b1;
      i.s1 = s1; i.e1 = 1'b1; i.s2 = s2; i.e2 = 1'b1;
      return i;
   endfunction

   function automatic ins_t f_ld(input logic [1:0] d, input logic [1:0] a);
      ins_t i = '0;
      i.v = 1'b1; i.d = d; i.wb = 1'b1; i.rd = 1'b1;
      i.s1 = a; i.e1 = 1'b1;
      return i;
   endfunction

   function automatic ins_t f_st(input logic [1:0] data, input logic data_en, input logic [1:0] a);
      ins_t i = '0;
      i.v = 1'b1; i.wr = 1'b1;
      i.s1 = data; i.e1 = data_en; i.s2 = a; i.e2 = 1'b1;
      return i;
   endfunction

   function automatic ins_t f_br(input logic [1:0] s, input logic taken);
      ins_t i = '0;
      i.v = 1'b1; i.s1 = s; i.e1 = 1'b1; i.br = taken;
      return i;
   endfunction

   function automatic logic [6:0] obs_of(input int w);
      case (w)
         0:       return obs_a;
         1:       return obs_b;
         default: return obs_c;
      endcase
   endfunction

   task automatic applyStimulus(input ins_t i);
      id_valid    = i.v;
      id_src1     = i.s1;
      id_src1_en  = i.e1;
      id_src2     = i.s2;
      id_src2_en  = i.e2;
      id_dest     = i.d;
      id_wb_en    = i.wb;
      id_mem_rd   = i.rd;
      id_mem_wr   = i.wr;
      id_br_taken = i.br;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      applyStimulus(f_nop());
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
   endtask

   // Loads presented during reset must leave nothing behind
   task automatic test_reset();
      ins_t       prog [2];
      logic [6:0] exp [2];
      logic [6:0] e;
      prog = '{f_alu(2'd2, 2'd1, 2'd1), f_nop()};
      exp  = '{E_IDLE, E_IDLE};
      rst = 1'b0;
      applyStimulus(f_ld(2'd1, 2'd0));
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (dut_a.rdy_cnt[i] !== 3'd0)
            $display("[TB] FAIL reset_rdy_cnt[%0d]: got %0d, expected 0", i, dut_a.rdy_cnt[i]);
         else passes++;
      end
      for (int k = 0; k < 2; k++) begin
         applyStimulus(prog[k]);
         sb.push_back(exp[k]);
         @(negedge clk);
         e = sb.pop_front();
         checks++;
         if (obs_of(0) !== e) $display("[TB] FAIL reset[%0d]: got %b, expected %b", k, obs_of(0), e);
         else passes++;
         @(posedge clk); #1;
      end
   endtask

   // Dependent ALU chain, then MEM-over-WB priority on operand 2
   task automatic test_alu_chain();
      ins_t       prog [8];
      logic [6:0] exp [8];
      logic [6:0] e;
      prog = '{f_alu(2'd1, 2'd2, 2'd3), f_alu(2'd2, 2'd1, 2'd3), f_alu(2'd3, 2'd1, 2'd0), f_nop(),
               f_alu(2'd1, 2'd0, 2'd0), f_alu(2'd1, 2'd0, 2'd0), f_alu(2'd2, 2'd3, 2'd1), f_nop()};
      exp  = '{E_IDLE, E_IDLE, E_S1M, E_S1W, E_IDLE, E_IDLE, E_IDLE, E_S2M};
      do_reset();
      for (int k = 0; k < 8; k++) begin
         applyStimulus(prog[k]);
         sb.push_back(exp[k]);
         @(negedge clk);
         e = sb.pop_front();
         checks++;
         if (obs_of(0) !== e) $display("[TB] FAIL alu_chain[%0d]: got %b, expected %b", k, obs_of(0), e);
         else passes++;
         @(posedge clk); #1;
      end
   endtask

   // Load-use with a one-cycle memory: single bubble, then WB forward
   task automatic test_load_use();
      ins_t       prog [4];
      logic [6:0] exp [4];
      logic [6:0] e;
      prog = '{f_ld(2'd2, 2'd1), f_alu(2'd3, 2'd2, 2'd0), f_alu(2'd3, 2'd2, 2'd0), f_nop()};
      exp  = '{E_IDLE, E_STALL, E_IDLE, E_S1W};
      do_reset();
      for (int k = 0; k < 4; k++) begin
         applyStimulus(prog[k]);
         sb.push_back(exp[k]);
         @(negedge clk);
         e = sb.pop_front();
         checks++;
         if (obs_of(0) !== e) $display("[TB] FAIL load_use[%0d]: got %b, expected %b", k, obs_of(0), e);
         else passes++;
         @(posedge clk); #1;
      end
   endtask

   // Load-use with a three-cycle memory: three stall cycles
   task automatic test_load_use_lat3();
      ins_t       prog [6];
      logic [6:0] exp [6];
      logic [6:0] e;
      prog = '{f_ld(2'd2, 2'd1), f_alu(2'd3, 2'd2, 2'd0), f_alu(2'd3, 2'd2, 2'd0),
               f_alu(2'd3, 2'd2, 2'd0), f_alu(2'd3, 2'd2, 2'd0), f_nop()};
      exp  = '{E_IDLE, E_STALL, E_STALL, E_STALL, E_IDLE, E_IDLE};
      do_reset();
      for (int k = 0; k < 6; k++) begin
         applyStimulus(prog[k]);
         sb.push_back(exp[k]);
         @(negedge clk);
         e = sb.pop_front();
         checks++;
         if (obs_of(1) !== e) $display("[TB] FAIL load_use_lat3[%0d]: got %b, expected %b", k, obs_of(1), e);
         else passes++;
         @(posedge clk); #1;
      end
   endtask

   // Taken branch held by a load hazard flushes only once it issues
   task automatic test_branch();
      ins_t       prog [6];
      logic [6:0] exp [6];
      logic [6:0] e;
      prog = '{f_ld(2'd1, 2'd0), f_br(2'd1, 1'b1), f_br(2'd1, 1'b1), f_nop(),
               f_br(2'd3, 1'b1), f_br(2'd3, 1'b0)};
      exp  = '{E_IDLE, E_STALL, E_FLUSH, E_S1W, E_FLUSH, E_IDLE};
      do_reset();
      for (int k = 0; k < 6; k++) begin
         applyStimulus(prog[k]);
         sb.push_back(exp[k]);
         @(negedge clk);
         e = sb.pop_front();
         checks++;
         if (obs_of(0) !== e) $display("[TB] FAIL branch[%0d]: got %b, expected %b", k, obs_of(0), e);
         else passes++;
         @(posedge clk); #1;
      end
   endtask

   // Store data forwarded from WB while the store sits in MEM
   task automatic test_store_fwd();
      ins_t       prog [8];
      logic [6:0] exp [8];
      logic [6:0] e;
      prog = '{f_ld(2'd1, 2'd0), f_st(2'd1, 1'b0, 2'd2), f_nop(), f_nop(),
               f_alu(2'd3, 2'd0, 2'd0), f_st(2'd3, 1'b1, 2'd2), f_nop(), f_nop()};
      exp  = '{E_IDLE, E_IDLE, E_IDLE, E_ST, E_IDLE, E_IDLE, E_S1M, E_ST};
      do_reset();
      for (int k = 0; k < 8; k++) begin
         applyStimulus(prog[k]);
         sb.push_back(exp[k]);
         @(negedge clk);
         e = sb.pop_front();
         checks++;
         if (obs_of(0) !== e) $display("[TB] FAIL store_fwd[%0d]: got %b, expected %b", k, obs_of(0), e);
         else passes++;
         @(posedge clk); #1;
      end
   endtask

   // Hardwired r0: a load to r0 never stalls readers, nothing forwards r0
   task automatic test_zero_reg();
      ins_t       prog [4];
      logic [6:0] exp [4];
      logic [6:0] e;
      prog = '{f_ld(2'd0, 2'd1), f_st(2'd0, 1'b1, 2'd0), f_alu(2'd2, 2'd0, 2'd0), f_nop()};
      exp  = '{E_IDLE, E_IDLE, E_IDLE, E_IDLE};
      do_reset();
      for (int k = 0; k < 4; k++) begin
         applyStimulus(prog[k]);
         sb.push_back(exp[k]);
         @(negedge clk);
         e = sb.pop_front();
         checks++;
         if (obs_of(2) !== e) $display("[TB] FAIL zero_reg[%0d]: got %b, expected %b", k, obs_of(2), e);
         else passes++;
         @(posedge clk); #1;
      end
   endtask

   // A younger ALU write to a loaded register cancels the pending load count
   task automatic test_waw();
      ins_t       prog [4];
      logic [6:0] exp [4];
      logic [6:0] e;
      prog = '{f_ld(2'd1, 2'd0), f_alu(2'd1, 2'd2, 2'd3), f_alu(2'd2, 2'd1, 2'd0), f_nop()};
      exp  = '{E_IDLE, E_IDLE, E_IDLE, E_S1M};
      do_reset();
      for (int k = 0; k < 4; k++) begin
         applyStimulus(prog[k]);
         sb.push_back(exp[k]);
         @(negedge clk);
         e = sb.pop_front();
         checks++;
         if (obs_of(1) !== e) $display("[TB] FAIL waw[%0d]: got %b, expected %b", k, obs_of(1), e);
         else passes++;
         if (k == 2) begin
            checks++;
            if (dut_b.rdy_cnt[1] !== 3'd0)
               $display("[TB] FAIL waw_rdy_cnt: got %0d, expected 0", dut_b.rdy_cnt[1]);
            else passes++;
         end
         @(posedge clk); #1;
      end
   endtask

   // Two loads back to back: the older count keeps draining while the
   // younger one is armed, so the reader waits for the later load
   task automatic test_back_to_back();
      ins_t       prog [7];
      logic [6:0] exp [7];
      logic [6:0] e;
      prog = '{f_ld(2'd1, 2'd0), f_ld(2'd2, 2'd0), f_alu(2'd3, 2'd1, 2'd2), f_alu(2'd3, 2'd1, 2'd2),
               f_alu(2'd3, 2'd1, 2'd2), f_alu(2'd3, 2'd1, 2'd2), f_nop()};
      exp  = '{E_IDLE, E_IDLE, E_STALL, E_STALL, E_STALL, E_IDLE, E_IDLE};
      do_reset();
      for (int k = 0; k < 7; k++) begin
         applyStimulus(prog[k]);
         sb.push_back(exp[k]);
         @(negedge clk);
         e = sb.pop_front();
         checks++;
         if (obs_of(1) !== e) $display("[TB] FAIL back_to_back[%0d]: got %b, expected %b", k, obs_of(1), e);
         else passes++;
         @(posedge clk); #1;
      end
   endtask

   // Test sequence
   initial begin
      rst = 1'b0;
      applyStimulus(f_nop());
      @(posedge clk); #1;
      $display("[TB] starting pipe_hazard_ctrl bench");
      test_reset();
      test_alu_chain();
      test_load_use();
      test_load_use_lat3();
      test_branch();
      test_store_fwd();
      test_zero_reg();
      test_waw();
      test_back_to_back();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
